// File: rtl/seven_segment_pkg.sv
// Shared segment encodings, converter FSM states and sizing/decode helpers
// for the multiplexed seven-segment display driver.
package seven_segment_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns.
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } conv_state_e;

    // ceil(width*log10(2)) + 1, with log10(2) approximated as 0.301.
    function automatic int bcd_nibbles(input int width);
        return (width * 301 + 999) / 1000 + 1;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/binary_to_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter with a valid/ready intake
// and a one-cycle done pulse while the finished result is presented.
module binary_to_bcd_converter
    import seven_segment_pkg::*;
#(
    parameter int DATA_WIDTH  = 14,
    parameter int BCD_NIBBLES = bcd_nibbles(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    value_i,
    input  logic                     value_valid_i,
    output logic                     value_ready_o,
    output logic [4*BCD_NIBBLES-1:0] bcd_o,
    output logic                     done_o
);

    localparam int BCD_W = 4 * BCD_NIBBLES;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    conv_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [BCD_W-1:0]      bcd_adj_s;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_q, ready_d;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < BCD_NIBBLES; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return adj;
    endfunction

    // Next-state logic: accept in IDLE, one shift-add-3 step per CONVERT cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bcd_d     = bcd_q;
        count_d   = count_q;
        bcd_adj_s = dabble_adjust(bcd_q);
        case (state_q)
            IDLE: begin
                if (value_valid_i && ready_q) begin
                    state_d = CONVERT;
                    shift_d = value_i;
                    bcd_d   = '0;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                bcd_d   = {bcd_adj_s[BCD_W-2:0], shift_q[DATA_WIDTH-1]};
                shift_d = shift_q << 1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d = LOAD;
                end else begin
                    state_d = CONVERT;
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bcd_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

    assign value_ready_o = ready_q;
    assign bcd_o         = bcd_q;
    assign done_o        = (state_q == LOAD);

endmodule

// File: rtl/seven_segment_display_driver.sv
// Time-multiplexed seven-segment driver: holds converted BCD digits and scans
// them onto an active-low segment bus with active-low one-hot digit enables.
module seven_segment_display_driver
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_WIDTH  = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  blank_leading_zeros,
    output logic [6:0]            seven_segment,
    output logic [NUM_DIGITS-1:0] digit_enable,
    output logic                  overflow
);

    localparam int BCD_NIBBLES = bcd_nibbles(DATA_WIDTH);
    localparam int BCD_W       = 4 * BCD_NIBBLES;
    localparam int DISP_W      = 4 * NUM_DIGITS;
    localparam int EXT_W       = (BCD_W > DISP_W) ? BCD_W : DISP_W;
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int REF_W       = $clog2(REFRESH_DIV);

    logic [BCD_W-1:0]      bcd_s;
    logic [EXT_W-1:0]      bcd_ext_s;
    logic                  done_s;
    logic [DISP_W-1:0]     digits_q, digits_d;
    logic                  overflow_q, overflow_d;
    logic [REF_W-1:0]      refresh_q, refresh_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] lead_zero_s;
    logic [3:0]            cur_nib_s;
    logic                  cur_lz_s;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;

    binary_to_bcd_converter #(
        .DATA_WIDTH  (DATA_WIDTH),
        .BCD_NIBBLES (BCD_NIBBLES)
    ) u_conv (
        .clk           (clk),
        .rst           (rst),
        .value_i       (value),
        .value_valid_i (value_valid),
        .value_ready_o (value_ready),
        .bcd_o         (bcd_s),
        .done_o        (done_s)
    );

    assign bcd_ext_s = EXT_W'(bcd_s);

    // Latch a finished conversion; any nonzero nibble beyond the display is overflow.
    always_comb begin
        digits_d   = digits_q;
        overflow_d = overflow_q;
        if (done_s) begin
            digits_d   = bcd_ext_s[DISP_W-1:0];
            overflow_d = |(bcd_ext_s >> DISP_W);
        end else begin
            digits_d   = digits_q;
            overflow_d = overflow_q;
        end
    end

    // Refresh divider and scan index, free-running regardless of the converter.
    always_comb begin
        refresh_d = refresh_q;
        idx_d     = idx_q;
        if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            refresh_d = refresh_q + REF_W'(1);
            idx_d     = idx_q;
        end
    end

    // Leading-zero map (digit k and everything above it is zero) and scanned-digit select.
    always_comb begin
        logic seen_nz;
        seen_nz     = 1'b0;
        lead_zero_s = '0;
        cur_nib_s   = 4'd0;
        cur_lz_s    = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            seen_nz        = seen_nz | (digits_q[4*k +: 4] != 4'd0);
            lead_zero_s[k] = ~seen_nz;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib_s = digits_q[4*k +: 4];
                cur_lz_s  = lead_zero_s[k];
            end else begin
                cur_nib_s = cur_nib_s;
                cur_lz_s  = cur_lz_s;
            end
        end
    end

    // Segment and enable patterns for the current index, registered together below.
    always_comb begin
        seg_d = SEG_BLANK;
        en_d  = ~(NUM_DIGITS'(1) << idx_q);
        if (overflow_q) begin
            seg_d = SEG_DASH;
        end else if (blank_leading_zeros && (idx_q != '0) && cur_lz_s) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(cur_nib_s);
        end
    end

    // Display, scan and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_q   <= '0;
            overflow_q <= 1'b0;
            refresh_q  <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            en_q       <= '1;
        end else begin
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            refresh_q  <= refresh_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            en_q       <= en_d;
        end
    end

    assign seven_segment = seg_q;
    assign digit_enable  = en_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_seven_segment_display_driver.sv
// Directed bench for the seven-segment driver: 4 digits, 14-bit input,
// 4-cycle refresh, expected segment patterns written out by hand.
module tb_seven_segment_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SB = 7'b1111111;
    localparam logic [6:0] SD = 7'b0111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] value;
    logic        value_valid;
    logic        value_ready;
    logic        blank_leading_zeros;
    logic [6:0]  seven_segment;
    logic [3:0]  digit_enable;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    seven_segment_display_driver #(
        .NUM_DIGITS  (4),
        .DATA_WIDTH  (14),
        .REFRESH_DIV (4)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .value               (value),
        .value_valid         (value_valid),
        .value_ready         (value_ready),
        .blank_leading_zeros (blank_leading_zeros),
        .seven_segment       (seven_segment),
        .digit_enable        (digit_enable),
        .overflow            (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_digit(input int k, output logic [6:0] seg);
        int         waits;
        logic [3:0] want;
        want  = ~(4'b0001 << k);
        waits = 0;
        @(negedge clk);
        while (digit_enable !== want && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        if (digit_enable !== want) check("scan_timeout", 32'(digit_enable), 32'(want));
        seg = seven_segment;
    endtask

    task automatic expect_display(input string tag, input logic [6:0] d3, input logic [6:0] d2,
                                  input logic [6:0] d1, input logic [6:0] d0);
        logic [6:0] s;
        read_digit(3, s); check({tag, "_d3"}, 32'(s), 32'(d3));
        read_digit(2, s); check({tag, "_d2"}, 32'(s), 32'(d2));
        read_digit(1, s); check({tag, "_d1"}, 32'(s), 32'(d1));
        read_digit(0, s); check({tag, "_d0"}, 32'(s), 32'(d0));
    endtask

    task automatic send_start(input logic [13:0] v, input string tag);
        int waits;
        waits = 0;
        while (value_ready !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check({tag, "_ready"}, 32'(value_ready), 32'd1);
        value       = v;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_busy);
        int lows;
        lows = 0;
        while (value_ready !== 1'b1 && lows < 50) begin
            lows++;
            @(negedge clk);
        end
        check({tag, "_busy"}, 32'(lows), 32'(exp_busy));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] e;
        rst                 = 1'b1;
        value               = 14'd0;
        value_valid         = 1'b0;
        blank_leading_zeros = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg",   32'(seven_segment), 32'(SB));
        check("rst_en",    32'(digit_enable),  32'hf);
        check("rst_ov",    32'(overflow),      32'd0);
        check("rst_ready", 32'(value_ready),   32'd0);
        rst = 1'b0;

        @(negedge clk);
        check("ready_after_rst", 32'(value_ready), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            if (i > 1) @(negedge clk);
            e = ~(4'b0001 << ((i - 1) / 4));
            check($sformatf("scan_en%0d", i),  32'(digit_enable),  32'(e));
            check($sformatf("scan_seg%0d", i), 32'(seven_segment), 32'(S0));
        end

        send_start(14'd1234, "v1234");
        wait_done("v1234", 15);
        check("v1234_ov", 32'(overflow), 32'd0);
        expect_display("v1234", S1, S2, S3, S4);

        blank_leading_zeros = 1'b1;
        send_start(14'd7, "v7");
        wait_done("v7", 15);
        expect_display("v7_blank", SB, SB, SB, S7);
        blank_leading_zeros = 1'b0;
        expect_display("v7_noblank", S0, S0, S0, S7);

        blank_leading_zeros = 1'b1;
        send_start(14'd12000, "v12000");
        wait_done("v12000", 15);
        check("v12000_ov", 32'(overflow), 32'd1);
        expect_display("v12000", SD, SD, SD, SD);
        send_start(14'd0, "v0");
        wait_done("v0", 15);
        check("v0_ov", 32'(overflow), 32'd0);
        expect_display("v0", SB, SB, SB, S0);
        blank_leading_zeros = 1'b0;

        send_start(14'd42, "v42");
        value       = 14'd5555;
        value_valid = 1'b1;
        repeat (3) @(negedge clk);
        value_valid = 1'b0;
        wait_done("v42", 12);
        repeat (2) @(negedge clk);
        check("v42_idle", 32'(value_ready), 32'd1);
        expect_display("v42", S0, S0, S4, S2);

        send_start(14'd9999, "v9999");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_seg",   32'(seven_segment), 32'(SB));
        check("midrst_en",    32'(digit_enable),  32'hf);
        check("midrst_ov",    32'(overflow),      32'd0);
        check("midrst_ready", 32'(value_ready),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 32'(value_ready), 32'd1);
        expect_display("post_rst", S0, S0, S0, S0);

        send_start(14'd567, "v567");
        wait_done("v567", 15);
        expect_display("v567", S0, S5, S6, S7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
